// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] BD_ZERO = 3'd0;
  localparam logic [2:0] BD_P1   = 3'd1;
  localparam logic [2:0] BD_P2   = 3'd2;
  localparam logic [2:0] BD_M1   = 3'd3;
  localparam logic [2:0] BD_M2   = 3'd4;

  // Number of radix-4 digits needed to cover b plus one extension bit.
  function automatic int booth_n(input int b_w);
    return (b_w + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit recoder: triplet of multiplier bits to partial product.
// Negative digits return the one's complement; the +1 is carried out on neg.
module booth_r4_enc
  import mul_pkg::*;
#(
  parameter int A_W = 16
) (
  input  logic [2:0]     trip,
  input  logic [A_W+1:0] a_ext,
  output logic [A_W+1:0] pp,
  output logic           neg
);

  logic [2:0] digit_s;

  // Recode the bit triplet into a signed Booth digit.
  always_comb begin
    digit_s = BD_ZERO;
    case (trip)
      3'b001, 3'b010: digit_s = BD_P1;
      3'b011:         digit_s = BD_P2;
      3'b100:         digit_s = BD_M2;
      3'b101, 3'b110: digit_s = BD_M1;
      default:        digit_s = BD_ZERO;
    endcase
  end

  // Select 0, +-A or +-2A for the digit.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit_s)
      BD_P1: pp = a_ext;
      BD_P2: pp = {a_ext[A_W:0], 1'b0};
      BD_M1: begin
        pp  = ~a_ext;
        neg = 1'b1;
      end
      BD_M2: begin
        pp  = ~{a_ext[A_W:0], 1'b0};
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed/unsigned per
// transaction, valid/ready on both sides with bubble-free back-to-back accepts.
module mul_booth_seq
  import mul_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product
);

  localparam int N     = booth_n(B_W);
  localparam int BX_W  = 2 * N + 1;
  localparam int B_EXT = 2 * N - B_W;
  localparam int ACC_W = A_W + 2 * N + 2;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [A_W+1:0]       a_ext_r;
  logic [BX_W-1:0]      b_ext_r;
  logic [ACC_W-1:0]     acc_r;
  logic                 out_valid_r;
  logic [A_W+B_W-1:0]   product_r;

  logic                 accept_s;
  logic [A_W+1:0]       a_ext_s;
  logic [BX_W-1:0]      b_ext_s;
  logic [2:0]           trip_s;
  logic [A_W+1:0]       pp_s;
  logic                 neg_s;
  logic [ACC_W-1:0]     pp_sx_s;
  logic [ACC_W-1:0]     acc_next_s;

  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign product   = product_r;

  // Extension with sign bits in two's-complement mode; b gets the implicit 0 below its LSB.
  assign a_ext_s = {{2{tc & a[A_W-1]}}, a};
  assign b_ext_s = {{B_EXT{tc & b[B_W-1]}}, b, 1'b0};

  booth_r4_enc #(.A_W(A_W)) u_enc (
    .trip  (trip_s),
    .a_ext (a_ext_r),
    .pp    (pp_s),
    .neg   (neg_s)
  );

  // Current digit triplet and the weighted accumulator update.
  always_comb begin
    trip_s     = 3'(b_ext_r >> {cnt_r, 1'b0});
    pp_sx_s    = {{(2 * N){pp_s[A_W+1]}}, pp_s} + ACC_W'(neg_s);
    acc_next_s = acc_r + (pp_sx_s << {cnt_r, 1'b0});
  end

  // Control FSM, operand capture, accumulation and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_ext_r     <= '0;
      b_ext_r     <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      product_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= BUSY;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
            product_r   <= acc_next_s[A_W+B_W-1:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= in_valid ? BUSY : IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
      // in_ready is never high in BUSY, so this cannot collide with accumulation.
      if (accept_s) begin
        a_ext_r <= a_ext_s;
        b_ext_r <= b_ext_s;
        acc_r   <= '0;
        cnt_r   <= '0;
      end
    end
  end

endmodule

// File: doc/mul_booth_seq.md
# mul_booth_seq

Iterative radix-4 Booth multiplier, parametrised in operand widths, with a per-transaction two's-complement/unsigned mode select and valid/ready handshakes on both sides. It is the area-optimised successor to the fixed 16x16 combinational two's-complement multiplier and sits in datapaths where one product every few cycles is sufficient. The default configuration of 16x16 signed is drop-in comparable to the combinational unit, apart from latency.

## Interface
- `A_W`, default 16: width of operand `a`; legal range 2..64.
- `B_W`, default 16: width of operand `b`; legal range 2..64.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands are presented.
- `in_ready`  out  1: the block accepts operands this cycle.
- `a`  in  A_W: multiplicand.
- `b`  in  B_W: multiplier (Booth-recoded).
- `tc`  in  1: 1 = both operands are two's complement; 0 = both are unsigned.
- `out_valid`  out  1: `product` is valid.
- `out_ready`  in  1: the consumer takes `product`.
- `product`  out  A_W+B_W: exact product, signed if `tc` was 1.

## Operation
- Constant `N = ceil((B_W+1)/2)` iterations; N is 9 at defaults.
- States:
  - IDLE: `in_ready`=1. On `in_valid`, capture `a`, `b`, `tc`; clear the accumulator and the iteration counter; go to BUSY.
  - BUSY: one Booth digit per cycle. Counter runs 0..N-1. At N-1, go to DONE.
  - DONE: `out_valid`=1 and `product` is held stable. On `out_ready`, go to IDLE, or directly back to BUSY if `in_valid` is accepted in the same cycle.
- `in_ready` = (IDLE) or (DONE and `out_ready`). This allows back-to-back operation with no bubble cycle.
- Operand extension:
  - `b` is extended to 2N+1 bits, including the implicit 0 below the LSB. The extension uses sign bits when `tc`=1 and zeros when `tc`=0.
  - `a` is extended to A_W+2 bits in the same way.
- Digit selection: each triplet of `b` bits selects a digit in {-2,-1,0,+1,+2}. The partial product is 0, ±A or ±2A. Negation is two's complement (invert plus one carry-in).
- Accumulation: partial product i is added at weight 4^i. Accumulator width is A_W+2N+2 bits. `product` is the low A_W+B_W bits. The result is exact for all inputs in both modes.
- Operands changing on the input pins while the block is BUSY have no effect.
- `in_valid` must not be used to abort a transaction; only `rst` aborts.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, counter=0, accumulator=0.
- Latency:
  - Operands accepted at rising edge t0.
  - `out_valid` rises after edge t0+N, i.e. 9 cycles at defaults.
  - `product` is registered and stable for the whole of DONE.
- Throughput: one product per N+1 cycles with back-to-back handshakes.
- Backpressure: with `out_ready`=0, DONE holds indefinitely and `in_ready`=0.
- Simultaneous `out_ready` and `in_valid` in DONE: the old product is consumed and the new operands are captured on the same edge. `out_valid` drops the next cycle.
- `rst` mid-BUSY or mid-DONE: outputs go to their reset values immediately and asynchronously. The in-flight result is discarded, and nothing is emitted after reset.
- `rst` deassertion is synchronised externally; the first accept is possible on the first edge after release.

## Structure
- Package `mul_pkg`:
  - state enum `{IDLE, BUSY, DONE}`;
  - Booth digit encoding constants (`BD_ZERO`, `BD_P1`, `BD_P2`, `BD_M1`, `BD_M2`);
  - function `booth_n(B_W)` that returns N.
- Sub-module `booth_r4_enc`: combinational. Takes a 3-bit triplet and the extended multiplicand; produces the partial product and the negate carry-in.
- The top level contains the FSM, the counter, the operand registers and the accumulator.

## Test plan
- Signed corner cases, `tc`=1, 16x16:
  - a=0xFFFF, b=0xFFFF → `product`=0x00000001;
  - a=0x8000, b=0x8000 → 0x40000000;
  - a=0x8000, b=0x7FFF → 0xC0008000.
- Unsigned, `tc`=0:
  - a=0xFFFF, b=0xFFFF → 0xFFFE0001;
  - a=0x8000, b=0x0002 → 0x00010000.
- Latency check: accept at edge t0 → `out_valid` first high after edge t0+9. Hold `out_ready`=0 for 5 cycles → `product` is stable and `in_ready`=0 throughout.
- Back-to-back operation:
  - keep `in_valid` and `out_ready` high for 3 operand pairs;
  - expect accepts spaced 10 cycles apart, no lost or duplicated results, and results in order.
- Reset mid-operation: assert `rst` at BUSY cycle 4 → `out_valid`=0 and `product`=0 immediately. After release, a=3, b=5 → 15 with no stale output.
- Random regression:
  - 10k random operand/mode pairs, at defaults and at A_W=7, B_W=12;
  - compare against a `$signed`/`$unsigned` behavioural product selected by `tc`.
